// File: rtl/led_line_fetcher_if.sv
// Framebuffer read port and shifter-side line handshake of led_line_fetcher.
// master: the fetcher; slave: framebuffer model plus shift-out engine.
interface led_line_fetcher_if #(
  parameter int FB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_LINES     = 8
);
  localparam int LIDX_W = $clog2(NUM_LINES);

  logic                     frame_start;
  logic [FB_ADDR_WIDTH-1:0] fb_addr;
  logic [DATA_WIDTH-1:0]    fb_data;
  logic [FB_ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     line_valid;
  logic [LIDX_W-1:0]        line_index;
  logic                     line_done;
  logic                     busy;

  modport master (
    input  frame_start, fb_data, rd_addr, line_done,
    output fb_addr, rd_data, line_valid, line_index, busy
  );
  modport slave (
    output frame_start, fb_data, rd_addr, line_done,
    input  fb_addr, rd_data, line_valid, line_index, busy
  );
endinterface

// File: rtl/led_line_fetcher.sv
// Prefetches LED scan lines from the framebuffer into a ping-pong line buffer.
// Define LED_LINE_FETCHER_GAMMA_EN to enable the in*(in+1)>>8 gamma stage.
module led_line_fetcher #(
  parameter int LINE_WIDTH    = 416,
  parameter int NUM_LINES     = 8,
  parameter int FB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH    = 8
) (
  input  logic               clk,
  input  logic               reset,
  led_line_fetcher_if.master bus
);
  localparam int PIX_W  = $clog2(LINE_WIDTH);
  localparam int LIDX_W = $clog2(NUM_LINES);
  localparam logic [FB_ADDR_WIDTH-1:0] LW_A      = FB_ADDR_WIDTH'(LINE_WIDTH);
  localparam logic [PIX_W-1:0]         LAST_PIX  = PIX_W'(LINE_WIDTH - 1);
  localparam logic [LIDX_W-1:0]        LAST_LINE = LIDX_W'(NUM_LINES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                     state_q;
  logic [PIX_W-1:0]           pix_q;
  logic [FB_ADDR_WIDTH-1:0]   fb_addr_q;
  logic [LIDX_W-1:0]          line_q, start_line;
  logic                       restart_q, drain_cnt_q, wbank_q, busy_q, drain_done;
  logic [1:0][LIDX_W-1:0]     tag_q;
  logic [1:0]                 full_q, full_d;
  logic                       front_q, front_d;
  logic [1:0]                 vld_pipe_q, vld_pipe_d;
  logic [1:0][PIX_W-1:0]      idx_pipe_q, idx_pipe_d;
  logic [DATA_WIDTH-1:0]      pix_data_q, pix_data_d, wr_data;
  logic [DATA_WIDTH-1:0]      rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]      mem_q [2][LINE_WIDTH];

  assign drain_done = (state_q == DRAIN) && drain_cnt_q;
  // A frame_start seen while idle applies to the very next fetch.
  assign start_line = bus.frame_start ? '0 : line_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      fb_addr_q   <= '0;
      line_q      <= '0;
      restart_q   <= 1'b0;
      drain_cnt_q <= 1'b0;
      wbank_q     <= 1'b0;
      busy_q      <= 1'b0;
      tag_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          line_q <= start_line;
          if (!full_q[wbank_q]) begin
            state_q        <= FETCH;
            busy_q         <= 1'b1;
            pix_q          <= '0;
            fb_addr_q      <= FB_ADDR_WIDTH'(start_line) * LW_A;
            tag_q[wbank_q] <= start_line;
          end
        end
        FETCH: begin
          if (bus.frame_start) restart_q <= 1'b1;
          if (pix_q == LAST_PIX) begin
            state_q     <= DRAIN;
            drain_cnt_q <= 1'b0;
          end else begin
            pix_q     <= pix_q + PIX_W'(1);
            fb_addr_q <= FB_ADDR_WIDTH'(line_q) * LW_A + FB_ADDR_WIDTH'(pix_q) + FB_ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          drain_cnt_q <= 1'b1;
          if (drain_cnt_q) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            wbank_q   <= ~wbank_q;
            restart_q <= 1'b0;
            line_q    <= (restart_q || bus.frame_start || line_q == LAST_LINE) ? '0 : line_q + LIDX_W'(1);
          end else if (bus.frame_start) begin
            restart_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fill and consume always target different banks, so both may land together.
  always_comb begin
    full_d  = full_q;
    front_d = front_q;
    if (drain_done) full_d[wbank_q] = 1'b1;
    if (bus.line_done && full_q[front_q]) begin
      full_d[front_q] = 1'b0;
      front_d         = ~front_q;
    end
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], state_q == FETCH};
    idx_pipe_d = {idx_pipe_q[0], pix_q};
    pix_data_d = vld_pipe_q[0] ? bus.fb_data : pix_data_q;
    rd_data_d  = (bus.rd_addr < LW_A) ? mem_q[front_q][bus.rd_addr[PIX_W-1:0]] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q     <= '0;
      front_q    <= 1'b0;
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
      pix_data_q <= '0;
      rd_data_q  <= '0;
    end else begin
      full_q     <= full_d;
      front_q    <= front_d;
      vld_pipe_q <= vld_pipe_d;
      idx_pipe_q <= idx_pipe_d;
      pix_data_q <= pix_data_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef LED_LINE_FETCHER_GAMMA_EN
  logic [2*DATA_WIDTH-1:0] sq;
  assign sq      = {{DATA_WIDTH{1'b0}}, pix_data_q} *
                   ({{DATA_WIDTH{1'b0}}, pix_data_q} + (2*DATA_WIDTH)'(1));
  assign wr_data = DATA_WIDTH'(sq >> DATA_WIDTH);
`else
  assign wr_data = pix_data_q;
`endif

  always_ff @(posedge clk) begin
    if (vld_pipe_q[1]) mem_q[wbank_q][idx_pipe_q[1]] <= wr_data;
  end

  assign bus.fb_addr    = fb_addr_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.line_valid = full_q[front_q];
  assign bus.line_index = tag_q[front_q];
  assign bus.busy       = busy_q;

`ifndef SYNTHESIS
  always @(posedge clk)
    assert (NUM_LINES * LINE_WIDTH <= (1 << FB_ADDR_WIDTH))
      else $error("scan lines exceed framebuffer address space");
`endif
endmodule

// File: tb/tb_led_line_fetcher.sv
// Directed bench for led_line_fetcher: framebuffer model returns fb_addr[7:0]
// (or a constant), read-back pixels are checked through a scoreboard queue.
module tb_led_line_fetcher;
  localparam int LW = 416, NL = 8, AW = 12, DW = 8;
`ifdef LED_LINE_FETCHER_GAMMA_EN
  localparam logic [7:0] EXP128 = 8'd64;
`else
  localparam logic [7:0] EXP128 = 8'd128;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic fb_const_en = 1'b0;
  logic [7:0] fb_const = 8'd0;
  logic seen_l7 = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  led_line_fetcher_if #(.FB_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LINES(NL)) bus ();

  led_line_fetcher #(.LINE_WIDTH(LW), .NUM_LINES(NL), .FB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  always @(posedge clk) bus.fb_data <= fb_const_en ? fb_const : bus.fb_addr[7:0];
  always @(negedge clk) if (bus.busy && bus.fb_addr == 12'd2912) seen_l7 <= 1'b1;

  function automatic logic [7:0] px(input int a);
    int v = a % 256;
`ifdef LED_LINE_FETCHER_GAMMA_EN
    return 8'((v * (v + 1)) >> 8);
`else
    return 8'(v);
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int w);
    return (w == 0) ? bus.line_valid : bus.busy;
  endfunction

  // Bounded wait; an expired bound shows up as a failed comparison.
  task automatic wait_sig(input string tag, input int w, input logic lvl, input int max);
    int n = 0;
    while (sel(w) !== lvl && n < max) begin tick(); n++; end
    chk(tag, 32'(sel(w)), 32'(lvl));
  endtask

  task automatic read_pix(input int a, input logic [7:0] e);
    bus.rd_addr = 12'(a);
    sb_q.push_back(32'(e));
    tick();
    chk($sformatf("rd_data[%0d]", a), 32'(bus.rd_data), sb_q.pop_front());
  endtask

  task automatic pulse_done();
    bus.line_done = 1'b1; tick(); bus.line_done = 1'b0;
  endtask

  task automatic restart_with_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus.frame_start = 1'b0; bus.line_done = 1'b0; bus.rd_addr = '0;
    tick(); tick(); tick();
    chk("rst_fb_addr", 32'(bus.fb_addr), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_line_valid", 32'(bus.line_valid), 0);
    chk("rst_line_index", 32'(bus.line_index), 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // First line after reset release; a stray line_done while empty is ignored.
    reset = 1'b0;
    n = 0;
    while (!bus.line_valid && n < 2000) begin
      tick(); n++;
      if (n == 1) begin
        chk("first_busy", 32'(bus.busy), 1);
        chk("first_fb_addr", 32'(bus.fb_addr), 0);
      end
      if (n == 100) bus.line_done = 1'b1;
      if (n == 101) bus.line_done = 1'b0;
      if (n == 200) chk("fb_addr_pix199", 32'(bus.fb_addr), 199);
    end
    chk("first_line_cycles", 32'(n), 419);
    chk("first_line_index", 32'(bus.line_index), 0);
    read_pix(5, px(5));
    chk("line1_busy", 32'(bus.busy), 1);
    chk("line1_fb_addr", 32'(bus.fb_addr), 416);
    read_pix(415, px(415));
    read_pix(0, px(0));

    // No consumer: second bank fills, then the fetcher parks.
    wait_sig("park_busy", 1, 1'b0, 1000);
    chk("park_fb_addr", 32'(bus.fb_addr), 831);
    repeat (1000) tick();
    chk("park_fb_addr_hold", 32'(bus.fb_addr), 831);
    chk("park_busy_hold", 32'(bus.busy), 0);
    chk("park_line_index", 32'(bus.line_index), 0);

    // Consume eight lines: index walks 1..7 then wraps to 0.
    for (int k = 1; k <= 8; k++) begin
      sb_q.push_back(32'(k % NL));
      pulse_done();
      wait_sig($sformatf("valid_after_done%0d", k), 0, 1'b1, 1000);
      chk($sformatf("line_index_seq%0d", k), 32'(bus.line_index), sb_q.pop_front());
      read_pix(0, px((k % NL) * LW));
    end
    chk("line7_fb_addr_2912", 32'(seen_l7), 1);

    // Reset in the middle of a fetch clears outputs without a clock edge.
    n = 0;
    while (!(bus.busy && bus.fb_addr != 0) && n < 1000) begin tick(); n++; end
    chk("busy_before_reset", 32'(bus.busy), 1);
    repeat (20) tick();
    read_pix(3, px(3));
    reset = 1'b1; #1;
    chk("midrst_fb_addr", 32'(bus.fb_addr), 0);
    chk("midrst_rd_data", 32'(bus.rd_data), 0);
    chk("midrst_line_valid", 32'(bus.line_valid), 0);
    chk("midrst_line_index", 32'(bus.line_index), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    tick(); tick(); reset = 1'b0;

    // Refill both banks, then overlap line_done with the other bank's drain.
    wait_sig("refill_valid", 0, 1'b1, 600);
    tick();
    chk("refill_fb_addr", 32'(bus.fb_addr), 416);
    wait_sig("refill_park", 1, 1'b0, 1000);
    pulse_done();
    chk("front_line1", 32'(bus.line_index), 1);
    wait_sig("line2_busy", 1, 1'b1, 5);
    chk("line2_fb_addr", 32'(bus.fb_addr), 832);
    repeat (417) tick();
    bus.line_done = 1'b1; tick(); bus.line_done = 1'b0;
    chk("simul_line_valid", 32'(bus.line_valid), 1);
    chk("simul_line_index", 32'(bus.line_index), 2);
    wait_sig("line3_busy", 1, 1'b1, 5);
    chk("line3_fb_addr", 32'(bus.fb_addr), 1248);

    // frame_start during line 3 makes the following fetch line 0.
    repeat (50) tick();
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    wait_sig("line3_park", 1, 1'b0, 1000);
    chk("still_line2", 32'(bus.line_index), 2);
    pulse_done();
    chk("buffered_line3_valid", 32'(bus.line_valid), 1);
    chk("buffered_line3_index", 32'(bus.line_index), 3);
    wait_sig("restart_busy", 1, 1'b1, 5);
    chk("restart_fb_addr", 32'(bus.fb_addr), 0);
    wait_sig("restart_park", 1, 1'b0, 1000);
    pulse_done();
    chk("restart_valid", 32'(bus.line_valid), 1);
    chk("restart_line_index", 32'(bus.line_index), 0);
    read_pix(5, px(5));

    // Constant framebuffer contents exercise the data path mapping.
    fb_const_en = 1'b1; fb_const = 8'd128;
    restart_with_reset();
    wait_sig("const128_valid", 0, 1'b1, 600);
    read_pix(7, EXP128);
    fb_const = 8'd255;
    restart_with_reset();
    wait_sig("const255_valid", 0, 1'b1, 600);
    read_pix(300, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
